// File: rtl/rat_uart_tx_port.sv
// rat_uart_tx_port: RAT I/O-bus responder that queues OUT bytes in a small FIFO
// and sends them as 8N1 UART frames, with a status/interrupt register on a second port.
module rat_uart_tx_port #(
   parameter logic [7:0]  DATA_PORT_ID = 8'h40,
   parameter logic [7:0]  STAT_PORT_ID = 8'h41,
   parameter int unsigned BAUD_DIV     = 868,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       IO_STRB,
   output logic [7:0] IN_PORT,
   output logic       TX,
   output logic       INTR
);
   localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
   localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [4:0]      count_q, count_d;
   logic            ovf_q, ovf_d, ie_q, ie_d, pend_q, pend_d, intr_q;
   logic            empty_s, full_s, busy_s, pop_s, push_s, pend_set_s;
   logic            data_wr_s, stat_wr_s;

   assign empty_s   = (count_q == 5'd0);
   assign full_s    = (count_q == DEPTH_CNT);
   assign busy_s    = (state_q != S_IDLE);
   assign data_wr_s = IO_STRB && (PORT_ID == DATA_PORT_ID);
   assign stat_wr_s = IO_STRB && (PORT_ID == STAT_PORT_ID);
   // A full FIFO still takes the byte when the transmitter frees a slot on the same edge
   assign push_s    = data_wr_s && (!full_s || pop_s);

   // Transmit FSM: frame sequencing, baud timing and FIFO pops
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      pop_s      = 1'b0;
      pend_set_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = BAUD_LOAD;
               state_d = S_START;
            end else begin
               baud_d  = 16'd0;
            end
         end
         S_START: begin
            if (baud_q == 16'd0) begin
               baud_d  = BAUD_LOAD;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_q == 16'd0) begin
               baud_d  = BAUD_LOAD;
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               state_d = (idx_q == 3'd7) ? S_STOP : S_DATA;
            end else begin
               baud_d  = baud_q - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_q == 16'd0) begin
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  baud_d  = BAUD_LOAD;
                  state_d = S_START;
               end else begin
                  pend_set_s = 1'b1;
                  baud_d     = 16'd0;
                  state_d    = S_IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: begin
            baud_d  = 16'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level follows the current state and lands in a register, so TX never glitches
   always_comb begin
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   // FIFO occupancy and control/status next-state
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
      if (stat_wr_s && OUT_PORT[0]) begin
         ovf_d = 1'b0;
      end else if (data_wr_s && full_s && !pop_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      ie_d = stat_wr_s ? OUT_PORT[1] : ie_q;
      if (pend_set_s) begin
         pend_d = 1'b1;
      end else if (stat_wr_s && OUT_PORT[2]) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // State, FIFO pointers and status registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         baud_q   <= 16'd0;
         idx_q    <= 3'd0;
         shift_q  <= 8'h00;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
         ovf_q    <= 1'b0;
         ie_q     <= 1'b0;
         pend_q   <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
         rd_ptr_q <= pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ie_q     <= ie_d;
         pend_q   <= pend_d;
         intr_q   <= pend_d & ie_d;
      end
   end

   // FIFO storage needs no reset: occupancy is tracked by the pointers
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= OUT_PORT;
      end
   end

   always_comb begin
      if (PORT_ID == STAT_PORT_ID) begin
         IN_PORT = {2'b00, pend_q, ie_q, ovf_q, busy_s, full_s, empty_s};
      end else if (PORT_ID == DATA_PORT_ID) begin
         IN_PORT = {3'b000, count_q};
      end else begin
         IN_PORT = 8'h00;
      end
   end

   assign TX   = tx_q;
   assign INTR = intr_q;
endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Bench for rat_uart_tx_port: directed scenarios followed by random bus traffic, every
// cycle compared against a frame-level reference model (byte queue + position in frame).
module tb_rat_uart_tx_port;
   localparam int B = 4;
   localparam int D = 4;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic [7:0] IN_PORT;
   logic       TX;
   logic       INTR;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queued bytes, byte on the wire and cycle position inside its frame
   logic [7:0] q_m [$];
   logic [7:0] cur_m;
   logic       busy_m, ovf_m, ie_m, pend_m, tx_m, intr_m;
   int         pos_m;

   always #5 CLK = ~CLK;

   rat_uart_tx_port #(
      .DATA_PORT_ID(8'h40),
      .STAT_PORT_ID(8'h41),
      .BAUD_DIV(B),
      .FIFO_DEPTH(D)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .PORT_ID(PORT_ID),
      .OUT_PORT(OUT_PORT),
      .IO_STRB(IO_STRB),
      .IN_PORT(IN_PORT),
      .TX(TX),
      .INTR(INTR)
   );

   function automatic logic [7:0] model_read(input logic [7:0] pid);
      if (pid == 8'h41)
         return {2'b00, pend_m, ie_m, ovf_m, busy_m, (q_m.size() == D), (q_m.size() == 0)};
      else if (pid == 8'h40)
         return 8'(q_m.size());
      return 8'h00;
   endfunction

   task automatic model_edge(input logic s, input logic [7:0] p, input logic [7:0] d,
                             input logic rst);
      int   slot;
      int   pre_size;
      logic frame_end, pop, pset;
      if (rst) begin
         q_m.delete();
         busy_m = 1'b0; ovf_m = 1'b0; ie_m = 1'b0; pend_m = 1'b0;
         tx_m = 1'b1; intr_m = 1'b0; pos_m = 0;
         return;
      end
      slot     = pos_m / B;
      pre_size = q_m.size();
      // Frame = start bit, eight data bits LSB first, stop bit; each B cycles long
      if (!busy_m)       tx_m = 1'b1;
      else if (slot == 0) tx_m = 1'b0;
      else if (slot <= 8) tx_m = cur_m[slot-1];
      else                tx_m = 1'b1;
      frame_end = busy_m && (pos_m == 10*B-1);
      pop       = (!busy_m || frame_end) && (pre_size > 0);
      pset      = frame_end && !pop;
      if (busy_m) pos_m++;
      if (pset) busy_m = 1'b0;
      if (pop) begin
         cur_m  = q_m.pop_front();
         busy_m = 1'b1;
         pos_m  = 0;
      end
      if (s && p == 8'h40) begin
         if (pre_size < D || pop) q_m.push_back(d);
         else ovf_m = 1'b1;
      end
      if (s && p == 8'h41) begin
         if (d[0]) ovf_m = 1'b0;
         ie_m = d[1];
         if (d[2]) pend_m = 1'b0;
      end
      if (pset) pend_m = 1'b1;
      intr_m = pend_m & ie_m;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic [7:0] p, input logic [7:0] d, input logic rst);
      @(negedge CLK);
      RESET = rst; IO_STRB = s; PORT_ID = p; OUT_PORT = d;
      #1;
      check("in_port", IN_PORT, model_read(p));
      @(posedge CLK);
      model_edge(s, p, d, rst);
      #1;
      check("tx", {7'd0, TX}, {7'd0, tx_m});
      check("intr", {7'd0, INTR}, {7'd0, intr_m});
   endtask

   task automatic idle(input int n, input logic [7:0] p);
      for (int i = 0; i < n; i++) cyc(1'b0, p, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      cyc(1'b1, p, d, 1'b0);
   endtask

   // Idle until the model sits on the last cycle of a frame, so the next edge ends it
   task automatic wait_frame_end();
      int guard = 0;
      while (!(busy_m && pos_m == 10*B-1) && guard < 200) begin
         idle(1, 8'h41);
         guard++;
      end
      check("frame_end_timeout", {7'd0, guard < 200}, 8'h01);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((busy_m || q_m.size() != 0) && guard < 400) begin
         idle(1, 8'h41);
         guard++;
      end
      check("idle_timeout", {7'd0, guard < 400}, 8'h01);
   endtask

   initial begin
      int         r;
      logic [7:0] p;
      RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
      @(posedge CLK);
      model_edge(1'b0, 8'h00, 8'h00, 1'b1);
      cyc(1'b0, 8'h41, 8'h00, 1'b1);
      check("stat_reset", IN_PORT, 8'h01);
      check("tx_reset", {7'd0, TX}, 8'h01);

      // Single frame of A5 with interrupts masked
      wr(8'h40, 8'hA5);
      idle(2, 8'h41);
      check("tx_start_bit", {7'd0, TX}, 8'h00);
      wait_idle();
      idle(2, 8'h41);
      check("stat_done", IN_PORT, 8'h21);

      // Interrupt enable, then PEND clear coincident with frame completion
      wr(8'h41, 8'h06);
      check("intr_clr", {7'd0, INTR}, 8'h00);
      wr(8'h40, 8'h3C);
      wait_frame_end();
      wr(8'h41, 8'h06);
      check("pend_set_wins", {7'd0, INTR}, 8'h01);
      wr(8'h41, 8'h06);
      check("intr_cleared", {7'd0, INTR}, 8'h00);

      // Six back-to-back pushes: five accepted, one dropped
      for (int i = 0; i < 6; i++) wr(8'h40, 8'(8'h11 * (i + 1)));
      check("count_full", IN_PORT, 8'h04);
      idle(1, 8'h41);
      check("ovf_set", {7'd0, IN_PORT[3]}, 8'h01);
      wait_idle();
      idle(3, 8'h41);
      wr(8'h41, 8'h01);
      check("ovf_clr", {7'd0, IN_PORT[3]}, 8'h00);

      // Full FIFO while the stop bit ends with a pop: same-edge push accepted
      for (int i = 0; i < 5; i++) wr(8'h40, 8'($urandom_range(0, 255)));
      wait_frame_end();
      wr(8'h40, 8'hC3);
      check("count_pop_push", IN_PORT, 8'h04);
      idle(1, 8'h41);
      check("ovf_pop_push", {7'd0, IN_PORT[3]}, 8'h00);
      wait_idle();

      // Reset in the middle of the data bits with three bytes queued
      for (int i = 0; i < 4; i++) wr(8'h40, 8'($urandom_range(0, 255)));
      idle(3*B, 8'h41);
      cyc(1'b0, 8'h41, 8'h00, 1'b1);
      check("tx_after_reset", {7'd0, TX}, 8'h01);
      check("stat_after_reset", IN_PORT, 8'h01);
      idle(60, 8'h41);

      // Random bus traffic against the model
      for (int n = 0; n < 2000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      p = 8'h40;
         else if (r < 70) p = 8'h41;
         else             p = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 199) == 0)
            cyc(1'b0, p, 8'h00, 1'b1);
         else
            cyc(($urandom_range(0, 99) < 12), p, 8'($urandom_range(0, 255)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
